// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants, round helper functions and FSM encoding for sha2_core_v4.
package sha2_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COMP  = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        COMP  = ST_COMP,
        FINAL = ST_FINAL,
        HOLD  = ST_HOLD
    } state_t;

    localparam logic [255:0] IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [255:0] IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    // K_TAB[63] holds K[0]; use k_at() rather than indexing directly.
    localparam logic [63:0][31:0] K_TAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] k_at(input logic [5:0] idx);
        return K_TAB[6'd63 - idx];
    endfunction

    function automatic logic [255:0] iv_sel(input logic m224);
        return m224 ? IV_224 : IV_256;
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round; state packed {a,b,c,d,e,f,g,h} with a in the MSBs.
module sha2_round
    import sha2_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;
    assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
    assign t2 = bsig0(a) + maj(a, b, c);
    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_core_v4.sv
// SHA-256/224 compression core, ROUNDS_PER_CYCLE rounds per clock, internal chaining of H.
module sha2_core_v4
    import sha2_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic         first_block,
    input  logic         mode_224,
    output logic [255:0] digest,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);
    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [6:0] R_STEP = 7'(R);

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
        $error("sha2_core_v4: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t              state, state_nx;
    logic [6:0]          t;
    logic [15:0][31:0]   w;       // w[0] is W[t]
    logic [255:0]        h_reg;
    logic [255:0]        wv;
    logic                mode_q;
    logic [15+R:0][31:0] wx;
    logic [R:0][255:0]   chain;

    // Window already holds W[t..t+15], so every round this cycle reads w[k] directly;
    // the R new tail words (which may depend on each other) refill it for the next cycle.
    always_comb begin
        wx[15:0] = w;
        for (int k = 0; k < R; k++)
            wx[16+k] = ssig1(wx[14+k]) + wx[9+k] + ssig0(wx[1+k]) + wx[k];
    end

    assign chain[0] = wv;
    for (genvar k = 0; k < R; k++) begin : g_round
        sha2_round u_round (
            .state_in (chain[k]),
            .k        (k_at(t[5:0] + 6'(k))),
            .w        (w[k]),
            .state_out(chain[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = COMP;
            COMP:    if (t + R_STEP == 7'd64) state_nx = FINAL;
            FINAL:   state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t      <= '0;
            w      <= '0;
            h_reg  <= '0;
            wv     <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
                    t <= '0;
                    if (first_block) begin
                        h_reg  <= iv_sel(mode_224);
                        wv     <= iv_sel(mode_224);
                        mode_q <= mode_224;
                    end else begin
                        wv <= h_reg;
                    end
                end
                COMP: begin
                    wv <= chain[R];
                    w  <= wx[15+R:R];
                    t  <= t + R_STEP;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++)
                        h_reg[32*i +: 32] <= h_reg[32*i +: 32] + wv[32*i +: 32];
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);
    assign digest    = mode_q ? {h_reg[255:32], 32'h0} : h_reg;

endmodule
